// File: rtl/core_imem_axil_bridge_pkg.sv
// Shared types and constants for the fetch-side AXI4-Lite read bridge.
// Holds the AXI response codes, the fetch protection value and FSM encoding.
package core_imem_axil_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Instruction access, secure, unprivileged.
    localparam logic [2:0] ARPROT_IFETCH = 3'b100;

    localparam int unsigned FETCH_BYTES_LOG2 = 3;

    typedef enum logic [1:0] {
        BR_IDLE = 2'b00,
        BR_ADDR = 2'b01,
        BR_DATA = 2'b10
    } br_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/core_imem_axil_bridge.sv
// Fetch-port to AXI4-Lite read bridge: one outstanding AR, stale beats
// (request withdrawn or address moved) are consumed and dropped.
module core_imem_axil_bridge
    import core_imem_axil_bridge_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 64,
    parameter int unsigned MEM_DATA_W = 64
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  imem_req,
    input  logic [MEM_ADDR_W-1:0] imem_addr,
    output logic                  imem_gnt,
    output logic                  imem_err,
    output logic [MEM_DATA_W-1:0] imem_rdata,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [MEM_ADDR_W-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [MEM_DATA_W-1:0] m_rdata,
    input  logic [1:0]            m_rresp
);

    localparam logic [MEM_ADDR_W-1:0] ADDR_MASK =
        ~{{(MEM_ADDR_W-FETCH_BYTES_LOG2){1'b0}},
          {FETCH_BYTES_LOG2{1'b1}}};

    br_state_e             state_q, state_d;
    logic [MEM_ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [MEM_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [MEM_ADDR_W-1:0] req_word;
    logic                  match;

    assign req_word = imem_addr & ADDR_MASK;
    assign match    = imem_req && (req_word == a_addr_q);

    always_comb begin
        state_d   = state_q;
        a_addr_d  = a_addr_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        imem_gnt  = 1'b0;
        unique case (state_q)
            BR_IDLE: begin
                if (imem_req) begin
                    a_addr_d = req_word;
                    state_d  = BR_ADDR;
                end
            end
            BR_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = BR_DATA;
                end
            end
            BR_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    // A mismatched beat is still consumed so the bus drains.
                    if (match) begin
                        imem_gnt = 1'b1;
                        rdata_d  = m_rdata;
                        err_d    = resp_is_err(m_rresp);
                    end
                    state_d = BR_IDLE;
                end
            end
            default: begin
                state_d = BR_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= BR_IDLE;
            a_addr_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_addr_q <= a_addr_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign m_araddr   = a_addr_q;
    assign m_arprot   = ARPROT_IFETCH;
    assign imem_rdata = rdata_q;
    assign imem_err   = err_q;

endmodule

// File: tb/tb_core_imem_axil_bridge.sv
// Directed bench for core_imem_axil_bridge: per-scenario tasks with
// hand-computed expectations on cycle-by-cycle bus and fetch signals.
module tb_core_imem_axil_bridge;

    logic        g_clk;
    logic        g_resetn;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_err;
    logic [63:0] imem_rdata;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_rvalid;
    logic        m_rready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;

    int total;
    int bad;

    core_imem_axil_bridge #(
        .MEM_ADDR_W(64),
        .MEM_DATA_W(64)
    ) dut (
        .g_clk(g_clk),
        .g_resetn(g_resetn),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_err(imem_err),
        .imem_rdata(imem_rdata),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_araddr(m_araddr),
        .m_arprot(m_arprot),
        .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .m_rdata(m_rdata),
        .m_rresp(m_rresp)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiet();
        imem_req  = 1'b0;
        imem_addr = 64'h0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 64'h0;
        m_rresp   = 2'b00;
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        quiet();
        cyc();
        cyc();
        total++;
        if (m_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL rst_arvalid got=%b exp=0", m_arvalid);
        end
        total++;
        if (m_rready !== 1'b0) begin
            bad++;
            $display("FAIL rst_rready got=%b exp=0", m_rready);
        end
        total++;
        if (imem_gnt !== 1'b0) begin
            bad++;
            $display("FAIL rst_gnt got=%b exp=0", imem_gnt);
        end
        total++;
        if (imem_rdata !== 64'h0 || imem_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_rdata got=%h/%b exp=0/0", imem_rdata, imem_err);
        end
        total++;
        if (m_araddr !== 64'h0) begin
            bad++;
            $display("FAIL rst_araddr got=%h exp=0", m_araddr);
        end
        total++;
        if (m_arprot !== 3'b100) begin
            bad++;
            $display("FAIL arprot got=%b exp=100", m_arprot);
        end
        g_resetn = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        imem_req  = 1'b1;
        imem_addr = 64'h8000_0000;
        m_arready = 1'b1;
        settle();
        total++;
        if (m_arvalid !== 1'b0 || imem_gnt !== 1'b0) begin
            bad++;
            $display("FAIL single_c0 got=%b%b exp=00", m_arvalid, imem_gnt);
        end
        cyc();
        m_rvalid = 1'b1;
        m_rdata  = 64'h1122_3344_5566_7788;
        m_rresp  = 2'b00;
        settle();
        total++;
        if (m_arvalid !== 1'b1 || m_araddr !== 64'h8000_0000) begin
            bad++;
            $display("FAIL single_c1 got=%b/%h exp=1/80000000", m_arvalid, m_araddr);
        end
        total++;
        if (imem_gnt !== 1'b0 || m_rready !== 1'b0) begin
            bad++;
            $display("FAIL single_c1_gnt got=%b%b exp=00", imem_gnt, m_rready);
        end
        cyc();
        total++;
        if (imem_gnt !== 1'b1 || m_rready !== 1'b1) begin
            bad++;
            $display("FAIL single_c2_gnt got=%b%b exp=11", imem_gnt, m_rready);
        end
        cyc();
        quiet();
        settle();
        total++;
        if (imem_rdata !== 64'h1122_3344_5566_7788 || imem_err !== 1'b0) begin
            bad++;
            $display("FAIL single_c3 got=%h/%b exp=1122334455667788/0",
                     imem_rdata, imem_err);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        imem_req  = 1'b1;
        imem_addr = 64'h8000_0006;
        cyc();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) m_arready = 1'b1;
            settle();
            total++;
            if (m_arvalid !== 1'b1 || m_araddr !== 64'h8000_0000) begin
                bad++;
                $display("FAIL bp_ar%0d got=%b/%h exp=1/80000000",
                         i, m_arvalid, m_araddr);
            end
            cyc();
        end
        m_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if (m_rready !== 1'b1 || imem_gnt !== 1'b0 || m_arvalid !== 1'b0) begin
                bad++;
                $display("FAIL bp_wait%0d got=%b%b%b exp=100",
                         i, m_rready, imem_gnt, m_arvalid);
            end
            cyc();
        end
        m_rvalid = 1'b1;
        m_rdata  = 64'hA5A5_0000_5A5A_FFFF;
        settle();
        total++;
        if (imem_gnt !== 1'b1) begin
            bad++;
            $display("FAIL bp_gnt got=%b exp=1", imem_gnt);
        end
        cyc();
        quiet();
        settle();
        total++;
        if (imem_rdata !== 64'hA5A5_0000_5A5A_FFFF) begin
            bad++;
            $display("FAIL bp_rdata got=%h exp=a5a500005a5affff", imem_rdata);
        end
        cyc();
    endtask

    task automatic test_flush();
        imem_req  = 1'b1;
        imem_addr = 64'h8000_0008;
        m_arready = 1'b1;
        cyc();
        settle();
        total++;
        if (m_araddr !== 64'h8000_0008) begin
            bad++;
            $display("FAIL flush_ar0 got=%h exp=80000008", m_araddr);
        end
        cyc();
        imem_addr = 64'h8000_1000;
        settle();
        total++;
        if (imem_gnt !== 1'b0 || m_rready !== 1'b1) begin
            bad++;
            $display("FAIL flush_wait got=%b%b exp=01", imem_gnt, m_rready);
        end
        cyc();
        m_rvalid = 1'b1;
        m_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        settle();
        total++;
        if (imem_gnt !== 1'b0 || m_rready !== 1'b1) begin
            bad++;
            $display("FAIL flush_drop got=%b%b exp=01", imem_gnt, m_rready);
        end
        cyc();
        m_rvalid = 1'b0;
        settle();
        total++;
        if (imem_rdata !== 64'hA5A5_0000_5A5A_FFFF || m_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL flush_keep got=%h/%b exp=a5a500005a5affff/0",
                     imem_rdata, m_arvalid);
        end
        cyc();
        settle();
        total++;
        if (m_arvalid !== 1'b1 || m_araddr !== 64'h8000_1000) begin
            bad++;
            $display("FAIL flush_ar1 got=%b/%h exp=1/80001000", m_arvalid, m_araddr);
        end
        cyc();
        m_rvalid = 1'b1;
        m_rdata  = 64'h0102_0304_0506_0708;
        settle();
        total++;
        if (imem_gnt !== 1'b1) begin
            bad++;
            $display("FAIL flush_gnt got=%b exp=1", imem_gnt);
        end
        cyc();
        quiet();
        settle();
        total++;
        if (imem_rdata !== 64'h0102_0304_0506_0708) begin
            bad++;
            $display("FAIL flush_rdata got=%h exp=0102030405060708", imem_rdata);
        end
        cyc();
    endtask

    task automatic test_stall();
        imem_req  = 1'b1;
        imem_addr = 64'h8000_0020;
        m_arready = 1'b1;
        cyc();
        cyc();
        imem_req = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 64'hFFFF_EEEE_DDDD_CCCC;
        settle();
        total++;
        if (imem_gnt !== 1'b0 || m_rready !== 1'b1) begin
            bad++;
            $display("FAIL stall_drop got=%b%b exp=01", imem_gnt, m_rready);
        end
        cyc();
        m_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (m_arvalid !== 1'b0 || m_rready !== 1'b0) begin
                bad++;
                $display("FAIL stall_idle%0d got=%b%b exp=00", i, m_arvalid, m_rready);
            end
            cyc();
        end
        total++;
        if (imem_rdata !== 64'h0102_0304_0506_0708) begin
            bad++;
            $display("FAIL stall_keep got=%h exp=0102030405060708", imem_rdata);
        end
        quiet();
    endtask

    task automatic fetch_resp(input logic [63:0] addr,
                              input logic [63:0] data,
                              input logic [1:0] resp,
                              output logic gnt_seen);
        imem_req  = 1'b1;
        imem_addr = addr;
        m_arready = 1'b1;
        cyc();
        cyc();
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rresp  = resp;
        settle();
        gnt_seen = imem_gnt;
        cyc();
        quiet();
        settle();
    endtask

    task automatic test_error();
        logic g;
        fetch_resp(64'h8000_0010, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10, g);
        total++;
        if (g !== 1'b1 || imem_err !== 1'b1) begin
            bad++;
            $display("FAIL err_slv got=%b/%b exp=1/1", g, imem_err);
        end
        cyc();
        fetch_resp(64'h8000_0018, 64'h600D_600D_600D_600D, 2'b00, g);
        total++;
        if (g !== 1'b1 || imem_err !== 1'b0 || imem_rdata !== 64'h600D_600D_600D_600D) begin
            bad++;
            $display("FAIL err_clr got=%b/%b/%h exp=1/0/600d600d600d600d",
                     g, imem_err, imem_rdata);
        end
        cyc();
        fetch_resp(64'h8000_0040, 64'h4444_3333_2222_1111, 2'b11, g);
        total++;
        if (g !== 1'b1 || imem_err !== 1'b1) begin
            bad++;
            $display("FAIL err_dec got=%b/%b exp=1/1", g, imem_err);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        imem_req  = 1'b1;
        imem_addr = 64'h8000_0030;
        m_arready = 1'b0;
        cyc();
        settle();
        total++;
        if (m_arvalid !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre got=%b exp=1", m_arvalid);
        end
        g_resetn = 1'b0;
        cyc();
        total++;
        if (m_arvalid !== 1'b0 || imem_gnt !== 1'b0 ||
            imem_rdata !== 64'h0 || imem_err !== 1'b0) begin
            bad++;
            $display("FAIL rmid_rst got=%b%b/%h/%b exp=00/0/0",
                     m_arvalid, imem_gnt, imem_rdata, imem_err);
        end
        g_resetn  = 1'b1;
        m_arready = 1'b1;
        cyc();
        settle();
        total++;
        if (m_arvalid !== 1'b1 || m_araddr !== 64'h8000_0030) begin
            bad++;
            $display("FAIL rmid_ar got=%b/%h exp=1/80000030", m_arvalid, m_araddr);
        end
        cyc();
        m_rvalid = 1'b1;
        m_rdata  = 64'h7777_6666_5555_4444;
        m_rresp  = 2'b00;
        settle();
        total++;
        if (imem_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rmid_gnt got=%b exp=1", imem_gnt);
        end
        cyc();
        quiet();
        settle();
        total++;
        if (imem_rdata !== 64'h7777_6666_5555_4444 || imem_err !== 1'b0) begin
            bad++;
            $display("FAIL rmid_rdata got=%h/%b exp=7777666655554444/0",
                     imem_rdata, imem_err);
        end
        cyc();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_stall();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
